// File: rtl/iob_fifo_wr_arb_if.sv
// Requester-side and FIFO-write-side signals of the write arbiter.
// The arbiter connects through the slave modport; the requesters and FIFO connect through master.
interface iob_fifo_wr_arb_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32
);
  logic [N_REQ-1:0]        req_valid_i;
  logic [N_REQ*DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]        req_last_i;
  logic [N_REQ-1:0]        req_ready_o;
  logic                    w_en_o;
  logic [DATA_W-1:0]       w_data_o;
  logic                    w_full_i;
  logic [N_REQ-1:0]        grant_o;
  logic                    busy_o;
  logic [N_REQ-1:0]        ovf_o;

  modport master (
    output req_valid_i, req_data_i, req_last_i, w_full_i,
    input  req_ready_o, w_en_o, w_data_o, grant_o, busy_o, ovf_o
  );

  modport slave (
    input  req_valid_i, req_data_i, req_last_i, w_full_i,
    output req_ready_o, w_en_o, w_data_o, grant_o, busy_o, ovf_o
  );
endinterface

// File: rtl/iob_fifo_wr_arb.sv
// Round-robin packet arbiter feeding one sync FIFO write port from N_REQ requesters.
// A grant is held for a whole packet, or until MAX_BEATS beats force a release.
module iob_fifo_wr_arb #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 32,
  parameter int MAX_BEATS = 16
) (
  input logic               clk_i,
  input logic               rst_i,
  input logic               cke_i,
  iob_fifo_wr_arb_if.slave  bus
);
  localparam int IDX_W = $clog2(N_REQ);
  localparam int SUM_W = IDX_W + 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BEATS - 1);
  localparam logic [IDX_W-1:0] IDX_MAX  = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_nxt, gidx, gidx_nxt, pick_idx;
  logic [N_REQ-1:0]   grant, grant_nxt, ovf, ovf_nxt, ready;
  logic [CNT_W-1:0]   beat_cnt, beat_cnt_nxt;
  logic [SUM_W-1:0]   cand;
  logic               pick_vld, accept, beat_last;

  // Scanning offsets downward leaves the nearest valid requester at or above rr_ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr;
    cand     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      cand = {1'b0, rr_ptr} + SUM_W'(i);
      if (cand >= SUM_W'(N_REQ)) cand = cand - SUM_W'(N_REQ);
      if (bus.req_valid_i[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  // Reset and clock-enable gate ready so no beat slips through a frozen or resetting cycle.
  always_comb begin
    ready = '0;
    if (state == BURST && !rst_i) ready[gidx] = cke_i & ~bus.w_full_i;
  end

  assign accept          = bus.req_valid_i[gidx] & ready[gidx];
  assign beat_last       = bus.req_last_i[gidx];
  assign bus.req_ready_o = ready;
  assign bus.w_en_o      = accept;
  assign bus.w_data_o    = bus.req_data_i[int'(gidx)*DATA_W +: DATA_W];
  assign bus.grant_o     = grant;
  assign bus.busy_o      = (state == BURST);
  assign bus.ovf_o       = ovf;

  always_comb begin
    state_nxt    = state;
    grant_nxt    = grant;
    gidx_nxt     = gidx;
    rr_ptr_nxt   = rr_ptr;
    beat_cnt_nxt = beat_cnt;
    ovf_nxt      = ovf;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt    = BURST;
          gidx_nxt     = pick_idx;
          grant_nxt    = N_REQ'(1) << pick_idx;
          beat_cnt_nxt = '0;
        end
      end
      BURST: begin
        if (accept) begin
          beat_cnt_nxt = beat_cnt + 1'b1;
          if (beat_last || beat_cnt == CNT_LAST) begin
            state_nxt  = IDLE;
            grant_nxt  = '0;
            rr_ptr_nxt = (gidx == IDX_MAX) ? '0 : gidx + 1'b1;
            if (!beat_last) ovf_nxt[gidx] = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      grant    <= '0;
      gidx     <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      ovf      <= '0;
    end else if (cke_i) begin
      state    <= state_nxt;
      grant    <= grant_nxt;
      gidx     <= gidx_nxt;
      rr_ptr   <= rr_ptr_nxt;
      beat_cnt <= beat_cnt_nxt;
      ovf      <= ovf_nxt;
    end
  end
endmodule

// File: tb/tb_iob_fifo_wr_arb.sv
// Scoreboard bench for iob_fifo_wr_arb: requester models drive packets, expected FIFO words
// and per-cycle grants are predicted by each scenario and compared as the DUT writes.
module tb_iob_fifo_wr_arb;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst, cke;
  always #5 clk = ~clk;

  iob_fifo_wr_arb_if #(.N_REQ(N), .DATA_W(DW)) bus ();
  iob_fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BEATS(MB)) dut (
    .clk_i(clk), .rst_i(rst), .cke_i(cke), .bus(bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] exp_q[$];
  logic [N-1:0]  glog[$];
  int pkt_len[N], beat_idx[N], pkts_left[N], tag[N];
  bit no_last[N];

  function automatic logic [DW-1:0] mk(input int k, input int t, input int b);
    return {8'(k), 8'(t), 16'(b)};
  endfunction

  task automatic set_pkt(input int k, input int len, input int cnt, input int t, input bit nl);
    pkt_len[k] = len; beat_idx[k] = 0; pkts_left[k] = cnt; tag[k] = t; no_last[k] = nl;
  endtask

  task automatic clear_model();
    for (int k = 0; k < N; k++) set_pkt(k, 0, 0, 0, 1'b0);
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < N; k++) begin
      bus.req_valid_i[k]         = (beat_idx[k] < pkt_len[k]);
      bus.req_data_i[k*DW +: DW] = mk(k, tag[k], beat_idx[k]);
      bus.req_last_i[k]          = !no_last[k] && (beat_idx[k] == pkt_len[k] - 1);
    end
  endtask

  task automatic advance(input int k);
    beat_idx[k]++;
    if (beat_idx[k] >= pkt_len[k] && pkts_left[k] > 1) begin
      pkts_left[k]--; tag[k]++; beat_idx[k] = 0;
    end
  endtask

  // One clock: sample at the falling edge, let requesters advance just after the rising edge.
  task automatic tick(output bit wrote);
    logic [N-1:0] acc;
    logic [DW-1:0] e;
    drive_inputs();
    @(negedge clk);
    glog.push_back(bus.grant_o);
    wrote = 1'b0;
    acc = '0;
    if (bus.w_en_o === 1'b1) begin
      wrote = 1'b1;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h required=no_write", bus.w_data_o);
      end else begin
        e = exp_q.pop_front();
        if (bus.w_data_o !== e) begin
          bad++;
          $display("FAIL write_data got=%h required=%h", bus.w_data_o, e);
        end
      end
    end
    for (int k = 0; k < N; k++) if (bus.req_valid_i[k] && bus.req_ready_o[k]) acc[k] = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (acc[k]) advance(k);
    drive_inputs();
  endtask

  task automatic apply_reset();
    rst = 1'b1; cke = 1'b0; bus.w_full_i = 1'b0;
    clear_model(); exp_q.delete(); drive_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; cke = 1'b1;
    total++; if (bus.grant_o !== '0) begin bad++; $display("FAIL rst_grant got=%b required=0", bus.grant_o); end
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b required=0", bus.busy_o); end
    total++; if (bus.ovf_o !== '0) begin bad++; $display("FAIL rst_ovf got=%b required=0", bus.ovf_o); end
    total++; if (bus.w_en_o !== 1'b0) begin bad++; $display("FAIL rst_wen got=%b required=0", bus.w_en_o); end
    glog.delete();
  endtask

  task automatic test_reset();
    bit w;
    apply_reset();
    set_pkt(3, 1, 1, 0, 1'b0);
    drive_inputs(); #1;
    total++; if (bus.req_ready_o !== '0) begin bad++; $display("FAIL idle_ready got=%b required=0", bus.req_ready_o); end
    total++; if (bus.w_en_o !== 1'b0) begin bad++; $display("FAIL idle_wen got=%b required=0", bus.w_en_o); end
    exp_q.push_back(mk(3, 0, 0));
    tick(w);
    total++; if (bus.grant_o !== 4'b1000) begin bad++; $display("FAIL first_grant got=%b required=1000", bus.grant_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL burst_busy got=%b required=1", bus.busy_o); end
    tick(w); tick(w);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL reset_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_two_req();
    bit w;
    logic [N-1:0] eg[$];
    apply_reset();
    set_pkt(1, 3, 1, 0, 1'b0);
    set_pkt(3, 3, 1, 0, 1'b0);
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(1, 0, b));
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(3, 0, b));
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000};
    for (int c = 0; c < 10; c++) tick(w);
    for (int i = 0; i < eg.size(); i++) begin
      total++;
      if (glog[i] !== eg[i]) begin bad++; $display("FAIL two_req_grant[%0d] got=%b required=%b", i, glog[i], eg[i]); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL two_req_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_rr();
    bit w;
    logic [N-1:0] eg[$];
    apply_reset();
    for (int k = 0; k < N; k++) set_pkt(k, 1, 2, 0, 1'b0);
    for (int t = 0; t < 2; t++) for (int k = 0; k < N; k++) exp_q.push_back(mk(k, t, 0));
    eg = '{4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000,
           4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000};
    for (int c = 0; c < 17; c++) tick(w);
    for (int i = 0; i < eg.size(); i++) begin
      total++;
      if (glog[i] !== eg[i]) begin bad++; $display("FAIL rr_grant[%0d] got=%b required=%b", i, glog[i], eg[i]); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rr_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_full();
    bit w;
    int nw = 0;
    apply_reset();
    set_pkt(0, MB, 1, 0, 1'b0);
    for (int b = 0; b < MB; b++) exp_q.push_back(mk(0, 0, b));
    for (int c = 0; c < 3; c++) begin tick(w); nw += int'(w); end
    bus.w_full_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick(w);
      total++; if (w) begin bad++; $display("FAIL full_write got=1 required=0"); end
      total++; if (glog[$] !== 4'b0001) begin bad++; $display("FAIL full_grant got=%b required=0001", glog[$]); end
    end
    bus.w_full_i = 1'b0;
    for (int c = 0; c < 4; c++) begin tick(w); nw += int'(w); end
    total++; if (nw != MB) begin bad++; $display("FAIL full_count got=%0d required=%0d", nw, MB); end
    total++; if (bus.ovf_o !== '0) begin bad++; $display("FAIL last_at_max_ovf got=%b required=0", bus.ovf_o); end
    total++; if (bus.grant_o !== '0) begin bad++; $display("FAIL full_release got=%b required=0", bus.grant_o); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_ovf();
    bit w;
    logic [N-1:0] eg[$];
    apply_reset();
    set_pkt(2, 6, 1, 0, 1'b1);
    for (int b = 0; b < 4; b++) exp_q.push_back(mk(2, 0, b));
    exp_q.push_back(mk(0, 0, 0));
    for (int b = 4; b < 6; b++) exp_q.push_back(mk(2, 0, b));
    eg = '{4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0000,
           4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0100};
    tick(w); tick(w);
    set_pkt(0, 1, 1, 0, 1'b0);
    for (int c = 0; c < 11; c++) tick(w);
    for (int i = 0; i < eg.size(); i++) begin
      total++;
      if (glog[i] !== eg[i]) begin bad++; $display("FAIL ovf_grant[%0d] got=%b required=%b", i, glog[i], eg[i]); end
    end
    total++; if (bus.ovf_o !== 4'b0100) begin bad++; $display("FAIL ovf_flag got=%b required=0100", bus.ovf_o); end
    total++; if (bus.busy_o !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b required=1", bus.busy_o); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL ovf_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit w;
    logic [N-1:0] eg[$];
    apply_reset();
    set_pkt(0, 5, 1, 0, 1'b0);
    exp_q.push_back(mk(0, 0, 0));
    exp_q.push_back(mk(0, 0, 1));
    for (int c = 0; c < 3; c++) tick(w);
    rst = 1'b1;
    set_pkt(0, 2, 1, 1, 1'b0);
    set_pkt(2, 1, 1, 0, 1'b0);
    tick(w);
    rst = 1'b0;
    total++; if (w) begin bad++; $display("FAIL mid_rst_write got=1 required=0"); end
    total++; if (bus.grant_o !== '0) begin bad++; $display("FAIL mid_rst_grant got=%b required=0", bus.grant_o); end
    total++; if (bus.ovf_o !== '0) begin bad++; $display("FAIL mid_rst_ovf got=%b required=0", bus.ovf_o); end
    exp_q.push_back(mk(0, 1, 0));
    exp_q.push_back(mk(0, 1, 1));
    exp_q.push_back(mk(2, 0, 0));
    glog.delete();
    eg = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0000};
    for (int c = 0; c < 6; c++) tick(w);
    for (int i = 0; i < eg.size(); i++) begin
      total++;
      if (glog[i] !== eg[i]) begin bad++; $display("FAIL mid_rst_grant[%0d] got=%b required=%b", i, glog[i], eg[i]); end
    end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_rst_drain got=%0d required=0", exp_q.size()); end
  endtask

  task automatic test_cke();
    bit w;
    int nw = 0;
    logic [N-1:0] eg[$];
    apply_reset();
    set_pkt(1, 3, 1, 0, 1'b0);
    for (int b = 0; b < 3; b++) exp_q.push_back(mk(1, 0, b));
    for (int c = 0; c < 2; c++) begin tick(w); nw += int'(w); end
    cke = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick(w);
      total++; if (w) begin bad++; $display("FAIL cke_write got=1 required=0"); end
      total++; if (bus.req_ready_o !== '0) begin bad++; $display("FAIL cke_ready got=%b required=0", bus.req_ready_o); end
    end
    cke = 1'b1;
    for (int c = 0; c < 3; c++) begin tick(w); nw += int'(w); end
    eg = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
    for (int i = 0; i < eg.size(); i++) begin
      total++;
      if (glog[i] !== eg[i]) begin bad++; $display("FAIL cke_grant[%0d] got=%b required=%b", i, glog[i], eg[i]); end
    end
    total++; if (nw != 3) begin bad++; $display("FAIL cke_count got=%0d required=3", nw); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL cke_drain got=%0d required=0", exp_q.size()); end
  endtask

  initial begin
    rst = 1'b1; cke = 1'b1; bus.w_full_i = 1'b0;
    clear_model(); drive_inputs();
    test_reset();
    test_two_req();
    test_rr();
    test_full();
    test_ovf();
    test_reset_mid();
    test_cke();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
